timer_cpu: RTL and testbench
============================

Name: timer_cpu

Overview:
Memory-mapped down-counting timer peripheral on the CPU bus, instantiated alongside io_cpu and uart_cpu. It consumes the CPU's address_o, data_o and we_o. It drives a registered read word into the CPU data mux (data_reg_inputs entry timer_e) and an interrupt request that is ORed into irq_combined. It provides a prescaled periodic or one-shot tick with a sticky expiry flag, for firmware delays and scheduling.

Parameters:
BaseAddress, 0, byte address of register 0.
address_width, 32, width of address_i.
data_width, 32, width of data_i/data_o and of the LOAD/COUNT registers.
PrescaleWidth, 16, width of the PRESCALE register and the prescaler counter.
Address_Wording, 4, byte stride between consecutive registers.

Ports:
clk_i  in  1  system clock, all logic rising-edge.
reset_n_i  in  1  synchronous, active-low reset.
address_i  in  address_width  CPU bus address.
data_i  in  data_width  CPU write data.
rd_wr_i  in  1  1 = write strobe this cycle, 0 = read.
data_o  out  data_width  registered read data to the CPU mux.
irq_o  out  1  level interrupt request, registered.

Behaviour:
- Register map (offset = index*Address_Wording from BaseAddress):
  - 0 CTRL: bit0 EN, bit1 PERIODIC, bit2 IRQ_EN; other bits read 0.
  - 1 PRESCALE: [PrescaleWidth-1:0].
  - 2 LOAD: [data_width-1:0].
  - 3 COUNT: read-only; writes ignored.
  - 4 STATUS: bit0 EXPIRED, write 1 to clear; bit1 RUNNING, read-only.
  - Unmapped offsets read 0 and ignore writes.
- Reset (reset_n_i=0 at a clk edge): CTRL=0, PRESCALE=0, LOAD=0, COUNT=0, prescaler counter=0, EXPIRED=0, state=IDLE, data_o=0, irq_o=0. Reset overrides any simultaneous write.
- Reads: data_o is registered from address_i one cycle after the address is presented. data_o=0 when address_i hits no register of this block. Reads have no side effects.
- Writes: take effect at the clk edge where rd_wr_i=1 and the address matches.
- State machine:
  - IDLE -> RUN on a CTRL write with EN=1 while in IDLE. Same edge: COUNT<=LOAD, prescaler<=0.
  - RUN -> IDLE on a CTRL write with EN=0. COUNT holds its value; EXPIRED is unchanged.
  - RUN -> IDLE on expiry in one-shot mode (PERIODIC=0). Hardware also clears CTRL.EN.
  - A CTRL write with EN=1 while in RUN only updates PERIODIC/IRQ_EN; no restart.
- Prescaler in RUN: counts 0..PRESCALE and emits a one-cycle tick when prescaler==PRESCALE, then returns to 0. Tick period is PRESCALE+1 clocks. PRESCALE=0 gives a tick every clock.
- On tick with COUNT!=0: COUNT<=COUNT-1.
- On tick with COUNT==0 (expiry): EXPIRED<=1. PERIODIC=1: COUNT<=LOAD. PERIODIC=0: go to IDLE.
  - Expiry period = (LOAD+1)*(PRESCALE+1) clocks.
  - LOAD=0 expires on every tick.
- LOAD written during RUN takes effect at the next reload or start only.
- PRESCALE written during RUN takes effect immediately. If prescaler > new PRESCALE, it wraps to 0 on the next clock with no tick.
- Simultaneous expiry and STATUS write-1-clear on the same edge: set wins, EXPIRED stays 1.
- RUNNING = (state==RUN).
- irq_o <= EXPIRED_next & IRQ_EN_next. irq_o deasserts the cycle after EXPIRED clears or IRQ_EN clears.
- COUNT is never written by the CPU. Decrement never wraps below 0.

Test Plan:
- Reset with irq_o forced X upstream; hold reset_n_i=0 two clocks -> every register reads 0, irq_o=0, data_o=0.
- PRESCALE=3, LOAD=4, CTRL=0b011 (EN+PERIODIC) -> EXPIRED sets 20 clocks after the CTRL write edge, then every 20 clocks. COUNT reads 4,3,2,1,0 as ticks occur.
- One-shot: PRESCALE=0, LOAD=2, CTRL=0b101 -> EXPIRED and irq_o go high after 3 clocks. Then CTRL reads 0b100, RUNNING=0, and COUNT stays 0.
- W1C race: LOAD=0, PRESCALE=0, periodic with IRQ_EN. Write STATUS=1 on an expiry edge -> EXPIRED remains 1. Write STATUS=1 with EN=0 -> EXPIRED=0 and irq_o=0 the next cycle.
- Mid-run changes: LOAD=10 running, write LOAD=2 at COUNT=7 -> countdown continues 6..0, then reloads 2. Write CTRL EN=0 at COUNT=5 -> COUNT holds 5, RUNNING=0.
- Bus decode: read BaseAddress+0x14 and an unrelated address -> data_o=0 one clock later. Write COUNT=0xFFFF -> COUNT unchanged.

Source files
------------

// File: rtl/timer_cpu.sv
`default_nettype none
// ============================================================================
// Module   : timer_cpu
// Purpose  : Memory-mapped prescaled down-counting timer, periodic or one-shot,
//            with a sticky expiry flag and a registered level interrupt.
// Revision : 1.0  initial release
// ============================================================================
module timer_cpu #(
    parameter int unsigned BASE_ADDRESS    = 0,
    parameter int unsigned ADDRESS_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned PRESCALE_WIDTH  = 16,
    parameter int unsigned ADDRESS_WORDING = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [ADDRESS_WIDTH-1:0] address_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    input  logic                     rd_wr_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     irq_o
);

    localparam logic [ADDRESS_WIDTH-1:0] c_addr_ctrl     = ADDRESS_WIDTH'(BASE_ADDRESS + 0 * ADDRESS_WORDING);
    localparam logic [ADDRESS_WIDTH-1:0] c_addr_prescale = ADDRESS_WIDTH'(BASE_ADDRESS + 1 * ADDRESS_WORDING);
    localparam logic [ADDRESS_WIDTH-1:0] c_addr_load     = ADDRESS_WIDTH'(BASE_ADDRESS + 2 * ADDRESS_WORDING);
    localparam logic [ADDRESS_WIDTH-1:0] c_addr_count    = ADDRESS_WIDTH'(BASE_ADDRESS + 3 * ADDRESS_WORDING);
    localparam logic [ADDRESS_WIDTH-1:0] c_addr_status   = ADDRESS_WIDTH'(BASE_ADDRESS + 4 * ADDRESS_WORDING);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    logic                      r_periodic;
    logic                      r_irq_en;
    logic [PRESCALE_WIDTH-1:0] r_prescale;
    logic [PRESCALE_WIDTH-1:0] r_presc_cnt;
    logic [DATA_WIDTH-1:0]     r_load;
    logic [DATA_WIDTH-1:0]     r_count;
    logic                      r_expired;

    state_t                    w_state_next;
    logic                      w_periodic_next;
    logic                      w_irq_en_next;
    logic [PRESCALE_WIDTH-1:0] w_prescale_next;
    logic [PRESCALE_WIDTH-1:0] w_presc_cnt_next;
    logic [DATA_WIDTH-1:0]     w_load_next;
    logic [DATA_WIDTH-1:0]     w_count_next;
    logic                      w_expired_next;
    logic [DATA_WIDTH-1:0]     w_rdata;

    logic w_hit_ctrl, w_hit_prescale, w_hit_load, w_hit_count, w_hit_status;
    logic w_wr_ctrl, w_wr_prescale, w_wr_load, w_wr_status;

    assign w_hit_ctrl     = (address_i == c_addr_ctrl);
    assign w_hit_prescale = (address_i == c_addr_prescale);
    assign w_hit_load     = (address_i == c_addr_load);
    assign w_hit_count    = (address_i == c_addr_count);
    assign w_hit_status   = (address_i == c_addr_status);

    assign w_wr_ctrl      = rd_wr_i & w_hit_ctrl;
    assign w_wr_prescale  = rd_wr_i & w_hit_prescale;
    assign w_wr_load      = rd_wr_i & w_hit_load;
    assign w_wr_status    = rd_wr_i & w_hit_status;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state     <= S_IDLE;
            r_periodic  <= 1'b0;
            r_irq_en    <= 1'b0;
            r_prescale  <= '0;
            r_presc_cnt <= '0;
            r_load      <= '0;
            r_count     <= '0;
            r_expired   <= 1'b0;
            data_o      <= '0;
            irq_o       <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_periodic  <= w_periodic_next;
            r_irq_en    <= w_irq_en_next;
            r_prescale  <= w_prescale_next;
            r_presc_cnt <= w_presc_cnt_next;
            r_load      <= w_load_next;
            r_count     <= w_count_next;
            r_expired   <= w_expired_next;
            data_o      <= w_rdata;
            irq_o       <= w_expired_next & w_irq_en_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_periodic_next  = r_periodic;
        w_irq_en_next    = r_irq_en;
        w_prescale_next  = r_prescale;
        w_presc_cnt_next = r_presc_cnt;
        w_load_next      = r_load;
        w_count_next     = r_count;
        w_expired_next   = r_expired;

        if (w_wr_ctrl) begin
            w_periodic_next = data_i[1];
            w_irq_en_next   = data_i[2];
        end
        if (w_wr_prescale) begin
            w_prescale_next = data_i[PRESCALE_WIDTH-1:0];
        end
        if (w_wr_load) begin
            w_load_next = data_i;
        end
        if (w_wr_status && data_i[0]) begin
            w_expired_next = 1'b0;
        end

        case (r_state)
            S_IDLE: begin
                if (w_wr_ctrl && data_i[0]) begin
                    w_state_next     = S_RUN;
                    w_count_next     = r_load;
                    w_presc_cnt_next = '0;
                end
            end
            S_RUN: begin
                // An explicit stop freezes COUNT, so it also swallows a coincident tick.
                if (w_wr_ctrl && !data_i[0]) begin
                    w_state_next = S_IDLE;
                end else if (r_presc_cnt > r_prescale) begin
                    w_presc_cnt_next = '0;
                end else if (r_presc_cnt == r_prescale) begin
                    w_presc_cnt_next = '0;
                    if (r_count != '0) begin
                        w_count_next = r_count - DATA_WIDTH'(1);
                    end else begin
                        w_expired_next = 1'b1;
                        if (r_periodic) begin
                            w_count_next = r_load;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end
                end else begin
                    w_presc_cnt_next = r_presc_cnt + PRESCALE_WIDTH'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // CTRL.EN is not stored separately: it is exactly "state is RUN".
    always_comb begin
        w_rdata = '0;
        if (w_hit_ctrl) begin
            w_rdata[2:0] = {r_irq_en, r_periodic, (r_state == S_RUN)};
        end else if (w_hit_prescale) begin
            w_rdata[PRESCALE_WIDTH-1:0] = r_prescale;
        end else if (w_hit_load) begin
            w_rdata = r_load;
        end else if (w_hit_count) begin
            w_rdata = r_count;
        end else if (w_hit_status) begin
            w_rdata[1:0] = {(r_state == S_RUN), r_expired};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_timer_cpu.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_cpu
// Purpose  : Directed self-checking bench for timer_cpu.
// Revision : 1.0  initial release
// ============================================================================
module tb_timer_cpu;

    localparam logic [31:0] c_ctrl   = 32'h00;
    localparam logic [31:0] c_presc  = 32'h04;
    localparam logic [31:0] c_load   = 32'h08;
    localparam logic [31:0] c_count  = 32'h0C;
    localparam logic [31:0] c_status = 32'h10;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd_wr;
    logic [31:0] data_o;
    logic        irq;
    logic [31:0] v;

    int n_cmp = 0;
    int n_err = 0;

    timer_cpu dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .address_i (addr),
        .data_i    (wdata),
        .rd_wr_i   (rd_wr),
        .data_o    (data_o),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; the write lands on the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        rd_wr = 1'b1;
        @(negedge clk);
        rd_wr = 1'b0;
    endtask

    // Returns the register value as it stood when the task was called.
    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr  = a;
        rd_wr = 1'b0;
        @(negedge clk);
        d = data_o;
    endtask

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        wdata = '0;
        rd_wr = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        rst_n = 1'b1;
        rd(c_ctrl, v);   chk("rst_ctrl", v, 32'd0);
        rd(c_presc, v);  chk("rst_presc", v, 32'd0);
        rd(c_load, v);   chk("rst_load", v, 32'd0);
        rd(c_count, v);  chk("rst_count", v, 32'd0);
        rd(c_status, v); chk("rst_status", v, 32'd0);

        // Periodic: PRESCALE=3, LOAD=4 -> period 20 clocks
        wr(c_presc, 32'd3);
        wr(c_load, 32'd4);
        wr(c_ctrl, 32'h3);
        addr = c_count;
        @(negedge clk);
        chk("per_count0", data_o, 32'd4);
        for (int i = 1; i < 5; i++) begin
            repeat (4) @(negedge clk);
            chk("per_count", data_o, 32'(4 - i));
        end
        addr = c_status;
        repeat (3) @(negedge clk);
        chk("per_pre_exp", data_o, 32'd2);
        @(negedge clk);
        chk("per_exp1", data_o, 32'd3);
        chk("per_irq_off", {31'd0, irq}, 32'd0);
        wr(c_status, 32'd1);
        addr = c_status;
        @(negedge clk);
        chk("per_clr", data_o, 32'd2);
        repeat (17) @(negedge clk);
        chk("per_pre_exp2", data_o, 32'd2);
        @(negedge clk);
        chk("per_exp2", data_o, 32'd3);
        wr(c_ctrl, 32'd0);
        wr(c_status, 32'd1);
        rd(c_status, v); chk("per_stopped", v, 32'd0);

        // One-shot: PRESCALE=0, LOAD=2, IRQ_EN
        wr(c_presc, 32'd0);
        wr(c_load, 32'd2);
        wr(c_ctrl, 32'h5);
        chk("os_irq0", {31'd0, irq}, 32'd0);
        repeat (2) @(negedge clk);
        chk("os_irq2", {31'd0, irq}, 32'd0);
        @(negedge clk);
        chk("os_irq3", {31'd0, irq}, 32'd1);
        rd(c_ctrl, v);   chk("os_ctrl", v, 32'h4);
        rd(c_status, v); chk("os_status", v, 32'h1);
        rd(c_count, v);  chk("os_count", v, 32'd0);
        repeat (3) @(negedge clk);
        rd(c_count, v);  chk("os_count_hold", v, 32'd0);

        // W1C race against continuous expiry
        wr(c_status, 32'd1);
        chk("w1c_irq_clr", {31'd0, irq}, 32'd0);
        wr(c_load, 32'd0);
        wr(c_ctrl, 32'h7);
        wr(c_status, 32'd1);
        rd(c_status, v); chk("w1c_race", v, 32'h3);
        chk("w1c_irq_on", {31'd0, irq}, 32'd1);
        wr(c_ctrl, 32'h6);
        wr(c_status, 32'd1);
        chk("w1c_irq_off", {31'd0, irq}, 32'd0);
        rd(c_status, v); chk("w1c_status", v, 32'd0);

        // Mid-run LOAD change and stop
        wr(c_load, 32'd10);
        wr(c_ctrl, 32'h3);
        addr = c_count;
        repeat (3) @(negedge clk);
        chk("mid_count8", data_o, 32'd8);
        wr(c_load, 32'd2);
        addr = c_count;
        @(negedge clk);
        chk("mid_count6", data_o, 32'd6);
        repeat (6) @(negedge clk);
        chk("mid_count0", data_o, 32'd0);
        @(negedge clk);
        chk("mid_reload", data_o, 32'd2);
        wr(c_load, 32'd10);
        repeat (6) @(negedge clk);
        wr(c_ctrl, 32'd0);
        rd(c_count, v);  chk("stop_count", v, 32'd5);
        rd(c_status, v); chk("stop_status", v, 32'd1);
        repeat (4) @(negedge clk);
        rd(c_count, v);  chk("stop_hold", v, 32'd5);

        // Bus decode
        rd(32'h14, v);        chk("dec_0x14", v, 32'd0);
        rd(c_count, v);       chk("dec_count", v, 32'd5);
        rd(32'h1000_0000, v); chk("dec_far", v, 32'd0);
        wr(c_count, 32'hFFFF);
        rd(c_count, v);       chk("dec_count_ro", v, 32'd5);
        wr(c_presc, 32'h12345);
        rd(c_presc, v);       chk("dec_presc_w", v, 32'h2345);
        wr(c_ctrl, 32'hFFFF_FFF8);
        rd(c_ctrl, v);        chk("dec_ctrl_rsv", v, 32'd0);
        rd(c_load, v);        chk("dec_load", v, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
